// File: rtl/fpu_host_if.sv
// fpu_host_if: host-bus front end for the FPU core with queued command/result
// FIFOs, status/control registers and a level result interrupt.
module fpu_host_if #(
    parameter int DATA_W    = 8,
    parameter int CMD_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int OP_W      = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [DATA_W-1:0] databus_in,
    output logic [DATA_W-1:0] databus_out,
    input  logic [3:0]        addr,
    input  logic              cs,
    input  logic              rd,
    input  logic              wr,
    input  logic              end_ack,
    output logic              cmd_end,
    output logic              busy,
    output logic [OP_W-1:0]   core_op,
    output logic [31:0]       core_a,
    output logic [31:0]       core_b,
    output logic              core_start,
    input  logic              core_done,
    input  logic [31:0]       core_result
);
    localparam int WORDS = 32 / DATA_W;
    localparam int CPW   = $clog2(CMD_DEPTH);
    localparam int RPW   = $clog2(RES_DEPTH);
    localparam int CMD_W = OP_W + 64;

    typedef enum logic [1:0] { IDLE, ISSUE, WAIT } state_t;
    state_t state;

    logic [31:0] op_a, op_b;
    logic        wr_prev, ack_prev;
    logic        irq_en, cmd_ovf;

    logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
    logic [CPW-1:0]   cmd_wptr, cmd_rptr;
    logic [CPW:0]     cmd_count;
    logic [31:0]      res_mem [RES_DEPTH];
    logic [RPW-1:0]   res_wptr, res_rptr, res_waddr;
    logic [RPW:0]     res_count;

    logic wr_stb, sel_cmd, sel_ctrl, flush;
    logic cmd_full, cmd_push, cmd_pop, cmd_drop;
    logic res_full, res_push, res_pop, ack_rise;
    logic [CMD_W-1:0] cmd_head;
    logic [31:0]      res_head;
    logic [7:0]       status;
    logic [3:0]       res_cnt4;

    // Write is edge-detected on the combined cs/wr strobe.
    assign wr_stb   = ~cs & ~wr & ~wr_prev;
    assign sel_cmd  = wr_stb && (addr == 4'h8);
    assign sel_ctrl = wr_stb && (addr == 4'hE);
    assign flush    = sel_ctrl && databus_in[2];

    assign cmd_full = (cmd_count == (CPW+1)'(CMD_DEPTH));
    assign cmd_pop  = (state == ISSUE) && (cmd_count != '0);
    assign cmd_push = sel_cmd && (!cmd_full || cmd_pop);
    assign cmd_drop = sel_cmd && cmd_full && !cmd_pop;
    assign cmd_head = cmd_mem[cmd_rptr];

    assign ack_rise  = end_ack & ~ack_prev;
    assign res_full  = (res_count == (RPW+1)'(RES_DEPTH));
    assign res_pop   = ack_rise && (res_count != '0);
    assign res_push  = (state == WAIT) && core_done && (flush || !res_full || res_pop);
    assign res_waddr = flush ? '0 : res_wptr;
    assign res_head  = res_mem[res_rptr];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_prev  <= 1'b0;
            ack_prev <= 1'b0;
            op_a     <= '0;
            op_b     <= '0;
            irq_en   <= 1'b1;
            cmd_ovf  <= 1'b0;
        end else begin
            wr_prev  <= ~cs & ~wr;
            ack_prev <= end_ack;
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (wr_stb && addr == 4'(w))
                    op_a[w*DATA_W +: DATA_W] <= databus_in;
                if (wr_stb && addr == 4'(4 + w))
                    op_b[w*DATA_W +: DATA_W] <= databus_in;
            end
            if (sel_ctrl) irq_en <= databus_in[0];
            if (sel_ctrl && databus_in[1]) cmd_ovf <= 1'b0;
            else if (cmd_drop)             cmd_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wptr] <= {databus_in[OP_W-1:0], op_a, op_b};
        if (res_push) res_mem[res_waddr] <= core_result;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
        end else if (flush) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
        end else begin
            if (cmd_push) cmd_wptr <= cmd_wptr + 1'b1;
            if (cmd_pop)  cmd_rptr <= cmd_rptr + 1'b1;
            cmd_count <= cmd_count + (CPW+1)'(cmd_push) - (CPW+1)'(cmd_pop);
        end
    end

    // A result landing in the flush cycle survives as the sole entry.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            res_wptr  <= '0;
            res_rptr  <= '0;
            res_count <= '0;
        end else if (flush) begin
            res_rptr  <= '0;
            res_wptr  <= res_push ? RPW'(1) : '0;
            res_count <= res_push ? (RPW+1)'(1) : '0;
        end else begin
            if (res_push) res_wptr <= res_wptr + 1'b1;
            if (res_pop)  res_rptr <= res_rptr + 1'b1;
            res_count <= res_count + (RPW+1)'(res_push) - (RPW+1)'(res_pop);
        end
    end

    // Operands are latched on entry to ISSUE so core_start rises two edges after the cmd write.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            core_op    <= '0;
            core_a     <= '0;
            core_b     <= '0;
            core_start <= 1'b0;
            busy       <= 1'b0;
            cmd_end    <= 1'b0;
        end else begin
            busy    <= (cmd_count != '0) || (state != IDLE);
            cmd_end <= irq_en && (res_count != '0);
            case (state)
                IDLE: begin
                    if (cmd_count != '0 && res_count < (RPW+1)'(RES_DEPTH)) begin
                        core_op    <= cmd_head[CMD_W-1 -: OP_W];
                        core_a     <= cmd_head[63:32];
                        core_b     <= cmd_head[31:0];
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        res_cnt4 = (32'(res_count) > 32'd15) ? 4'hF : 4'(res_count);
        status   = {res_cnt4, cmd_ovf, (res_count != '0), cmd_full, busy};
    end

    always_comb begin
        databus_out = '0;
        if (!cs && !rd) begin
            for (int unsigned w = 0; w < WORDS; w++) begin
                if (addr == 4'(w))     databus_out = op_a[w*DATA_W +: DATA_W];
                if (addr == 4'(4 + w)) databus_out = op_b[w*DATA_W +: DATA_W];
                if (addr == 4'(9 + w) && res_count != '0)
                    databus_out = res_head[w*DATA_W +: DATA_W];
            end
            if (addr == 4'hD) databus_out[7:0] = status;
        end
    end

endmodule

// File: tb/tb_fpu_host_if.sv
// Self-checking bench for fpu_host_if: an 8-bit-bus instance with an A+B core
// model and a 32-bit-bus instance for the wide access path.
module tb_fpu_host_if;
    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit instance
    logic [7:0]  din8 = '0, dout8;
    logic [3:0]  addr8 = '0;
    logic        cs8 = 1'b1, rd8 = 1'b1, wr8 = 1'b1, ack8 = 1'b0;
    logic        cmd_end8, busy8, start8, done8 = 1'b0;
    logic [3:0]  op8;
    logic [31:0] a8, b8, res8 = '0;

    fpu_host_if #(.DATA_W(8), .CMD_DEPTH(4), .RES_DEPTH(4), .OP_W(4)) u8 (
        .clk(clk), .arst(arst), .databus_in(din8), .databus_out(dout8),
        .addr(addr8), .cs(cs8), .rd(rd8), .wr(wr8), .end_ack(ack8),
        .cmd_end(cmd_end8), .busy(busy8), .core_op(op8), .core_a(a8),
        .core_b(b8), .core_start(start8), .core_done(done8), .core_result(res8)
    );

    // 32-bit instance
    logic [31:0] din32 = '0, dout32;
    logic [3:0]  addr32 = '0;
    logic        cs32 = 1'b1, rd32 = 1'b1, wr32 = 1'b1, ack32 = 1'b0;
    logic        cmd_end32, busy32, start32, done32 = 1'b0;
    logic [3:0]  op32;
    logic [31:0] a32, b32, res32 = '0;

    fpu_host_if #(.DATA_W(32), .CMD_DEPTH(4), .RES_DEPTH(4), .OP_W(4)) u32 (
        .clk(clk), .arst(arst), .databus_in(din32), .databus_out(dout32),
        .addr(addr32), .cs(cs32), .rd(rd32), .wr(wr32), .end_ack(ack32),
        .cmd_end(cmd_end32), .busy(busy32), .core_op(op32), .core_a(a32),
        .core_b(b32), .core_start(start32), .core_done(done32), .core_result(res32)
    );

    // Core models: result = A+B after a programmable latency; hold8 stalls the 8-bit core.
    int          lat8 = 5, cnt8 = 0, starts8 = 0, cnt32 = 0;
    logic        hold8 = 1'b0, act8 = 1'b0, act32 = 1'b0;
    logic [31:0] cap_a = '0, cap_b = '0;
    logic [3:0]  cap_op = '0;

    always @(posedge clk) begin
        done8 <= 1'b0;
        if (start8) begin
            starts8 <= starts8 + 1;
            cap_a   <= a8;
            cap_b   <= b8;
            cap_op  <= op8;
            res8    <= a8 + b8;
            cnt8    <= lat8;
            act8    <= 1'b1;
        end else if (act8 && !hold8) begin
            if (cnt8 <= 1) begin
                done8 <= 1'b1;
                act8  <= 1'b0;
            end else cnt8 <= cnt8 - 1;
        end
    end

    always @(posedge clk) begin
        done32 <= 1'b0;
        if (start32) begin
            res32 <= a32 + b32;
            cnt32 <= 5;
            act32 <= 1'b1;
        end else if (act32) begin
            if (cnt32 <= 1) begin
                done32 <= 1'b1;
                act32  <= 1'b0;
            end else cnt32 <= cnt32 - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        addr8 = a; din8 = d; cs8 = 1'b0; wr8 = 1'b0;
        @(negedge clk);
        wr8 = 1'b1; cs8 = 1'b1;
    endtask

    task automatic host_wr_word(input int base, input logic [31:0] v);
        for (int i = 0; i < 4; i++) host_wr(4'(base + i), v[i*8 +: 8]);
    endtask

    task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        addr8 = a; cs8 = 1'b0; rd8 = 1'b0;
        #1 d = dout8;
        cs8 = 1'b1; rd8 = 1'b1;
    endtask

    task automatic rd_result(output logic [31:0] v);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            host_rd(4'(9 + i), b);
            v[i*8 +: 8] = b;
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk); ack8 = 1'b1;
        @(negedge clk); ack8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_end(input int maxc);
        int n = 0;
        while (!cmd_end8 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("cmd_end_rise", 32'(cmd_end8), 32'd1);
    endtask

    task automatic host32_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr32 = a; din32 = d; cs32 = 1'b0; wr32 = 1'b0;
        @(negedge clk);
        wr32 = 1'b1; cs32 = 1'b1;
    endtask

    task automatic host32_rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        addr32 = a; cs32 = 1'b0; rd32 = 1'b0;
        #1 d = dout32;
        cs32 = 1'b1; rd32 = 1'b1;
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] sum;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  st;
        logic [3:0]  zaddr[6];
        int          s0;

        vecs[0] = '{32'h449a522c, 32'h458ebf1f, 4'h1, 32'h8a29114b};
        vecs[1] = '{32'h00000001, 32'hffffffff, 4'h2, 32'h00000000};
        vecs[2] = '{32'h12345678, 32'h11111111, 4'h3, 32'h23456789};
        vecs[3] = '{32'h7fffffff, 32'h00000001, 4'h4, 32'h80000000};
        vecs[4] = '{32'ha5a5a5a5, 32'h5a5a5a5a, 4'h5, 32'hffffffff};
        zaddr   = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hB, 4'hC};

        repeat (3) @(negedge clk);
        arst = 1'b0;
        check("rst_cmd_end", 32'(cmd_end8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_start", 32'(start8), 32'd0);
        check("rst_core_a", a8, 32'd0);
        host_rd(4'hD, st);
        check("rst_status", 32'(st), 32'h00);

        // Single commands through the 8-bit bus
        for (int i = 0; i < 5; i++) begin
            s0 = starts8;
            host_wr_word(0, vecs[i].a);
            host_wr_word(4, vecs[i].b);
            host_wr(4'h8, {4'h0, vecs[i].op});
            check("start_not_yet", 32'(start8), 32'd0);
            @(negedge clk);
            check("start_2_edges", 32'(start8), 32'd1);
            wait_end(60);
            check("start_once", 32'(starts8 - s0), 32'd1);
            check("core_a", cap_a, vecs[i].a);
            check("core_b", cap_b, vecs[i].b);
            check("core_op", 32'(cap_op), 32'(vecs[i].op));
            rd_result(v);
            check("result", v, vecs[i].sum);
            ack_pulse();
            check("cmd_end_fall", 32'(cmd_end8), 32'd0);
            check("busy_idle", 32'(busy8), 32'd0);
        end

        // 32-bit bus: single-access result, out-of-group words read 0
        host32_wr(4'h0, 32'h12345678);
        host32_wr(4'h4, 32'h0f0f0f0f);
        host32_wr(4'h8, 32'h3);
        for (int n = 0; n < 60 && !cmd_end32; n++) @(negedge clk);
        check("w32_cmd_end", 32'(cmd_end32), 32'd1);
        host32_rd(4'h9, v);
        check("w32_result", v, 32'h21436587);
        for (int i = 0; i < 6; i++) begin
            host32_rd(zaddr[i], v);
            check("w32_zero_addr", v, 32'd0);
        end
        @(negedge clk); ack32 = 1'b1;
        @(negedge clk); ack32 = 1'b0;
        repeat (2) @(negedge clk);
        check("w32_cmd_end_fall", 32'(cmd_end32), 32'd0);

        // Overflow: one command in flight on a stalled core, four queued, one dropped
        lat8 = 5; hold8 = 1'b1;
        host_wr_word(0, 32'h0);
        host_wr_word(4, 32'h100);
        s0 = starts8;
        for (int k = 1; k <= 6; k++) begin
            host_wr(4'h0, 8'(k));
            host_wr(4'h8, 8'h2);
        end
        repeat (3) @(negedge clk);
        host_rd(4'hD, st);
        check("status_ovf_full", 32'(st), 32'h0B);
        host_wr(4'hE, 8'h03);
        host_rd(4'hD, st);
        check("status_ovf_clr", 32'(st), 32'h03);
        hold8 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wait_end(100);
            rd_result(v);
            check("ovf_order", v, 32'h100 + 32'(k));
            ack_pulse();
        end
        repeat (10) @(negedge clk);
        check("ovf_executed", 32'(starts8 - s0), 32'd5);
        host_rd(4'hD, st);
        check("ovf_drained_status", 32'(st), 32'h00);

        // Result back-pressure: 1-cycle core, 6 commands, no ack until stalled
        lat8 = 1;
        s0 = starts8;
        for (int i = 0; i < 6; i++) begin
            host_wr(4'h0, 8'(8'h10 + i));
            host_wr(4'h8, 8'h2);
        end
        repeat (20) @(negedge clk);
        check("bp_stalled_starts", 32'(starts8 - s0), 32'd4);
        host_rd(4'hD, st);
        check("bp_status", 32'(st), 32'h45);
        check("bp_cmd_end", 32'(cmd_end8), 32'd1);
        for (int i = 0; i < 6; i++) begin
            rd_result(v);
            check("bp_order", v, 32'h110 + 32'(i));
            ack_pulse();
            repeat (8) @(negedge clk);
            check("bp_release", 32'(starts8 - s0), (i < 1) ? 32'd5 : 32'd6);
        end

        // wr held low for 3 clocks commits once; irq_en gates cmd_end only
        lat8 = 5;
        s0 = starts8;
        @(negedge clk);
        addr8 = 4'h8; din8 = 8'h2; cs8 = 1'b0; wr8 = 1'b0;
        repeat (3) @(negedge clk);
        wr8 = 1'b1; cs8 = 1'b1;
        repeat (20) @(negedge clk);
        check("wr_hold_one_push", 32'(starts8 - s0), 32'd1);
        host_rd(4'hD, st);
        check("wr_hold_status", 32'(st), 32'h14);
        host_wr(4'hE, 8'h00);
        repeat (2) @(negedge clk);
        check("irq_off", 32'(cmd_end8), 32'd0);
        host_wr(4'hE, 8'h01);
        repeat (2) @(negedge clk);
        check("irq_on", 32'(cmd_end8), 32'd1);
        rd_result(v);
        check("wr_hold_result", v, 32'h115);
        ack_pulse();

        // Reset while WAITing with two queued commands; late core_done ignored
        hold8 = 1'b1;
        s0 = starts8;
        for (int i = 0; i < 3; i++) host_wr(4'h8, 8'h2);
        repeat (4) @(negedge clk);
        check("pre_rst_busy", 32'(busy8), 32'd1);
        @(negedge clk);
        #2 arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        check("arst_start", 32'(start8), 32'd0);
        check("arst_op", 32'(op8), 32'd0);
        check("arst_a", a8, 32'd0);
        check("arst_b", b8, 32'd0);
        check("arst_busy", 32'(busy8), 32'd0);
        check("arst_cmd_end", 32'(cmd_end8), 32'd0);
        host_rd(4'hD, st);
        check("arst_status", 32'(st), 32'h00);
        hold8 = 1'b0;
        repeat (15) @(negedge clk);
        check("late_done_cmd_end", 32'(cmd_end8), 32'd0);
        check("late_done_no_issue", 32'(starts8 - s0), 32'd1);
        host_rd(4'hD, st);
        check("late_done_status", 32'(st), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
